// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch FSM with a show-ahead instruction queue
//
// Keeps the fetch PC and issues one word fetch at a time. Returned {pc, instr, jal}
// entries go into a circular queue that the decoder pops. JAL is redirected at fetch;
// other control flow is predicted not-taken and repaired by an ROB flush.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   rdy_i                 global enable; all state holds while low
//   mem_req_valid_o/addr  one-cycle fetch request pulse and word address
//   mem_rsp_valid_i/data  one response pulse per request with the instruction word
//   flush_i, flush_pc_i   redirect fetch and clear the queue
//   out_valid_o/ready_i   queue head handshake towards decode
//   out_instr_o, out_pc_o head instruction and its PC
//   out_pred_taken_o      head entry was a JAL already redirected by fetch
module ifetch_queue #(
  parameter int          QUEUE_ADDR_W = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_pred_taken_o
);

  localparam int DEPTH = 1 << QUEUE_ADDR_W;
  localparam logic [QUEUE_ADDR_W:0] FULL_CNT = {1'b1, {QUEUE_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t                  state_q;
  logic [31:0]             pc_q;
  logic [31:0]             pc_d;
  logic                    mem_req_valid_q;
  logic [31:0]             mem_req_addr_q;
  logic [QUEUE_ADDR_W-1:0] head_q;
  logic [QUEUE_ADDR_W-1:0] tail_q;
  logic [QUEUE_ADDR_W:0]   count_q;
  logic [QUEUE_ADDR_W:0]   count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        jal_mem   [DEPTH];

  logic        is_jal;
  logic [31:0] imm_j;
  logic        q_empty;
  logic        q_full;
  logic        issue;
  logic        push;
  logic        pop;

  always_comb begin
    is_jal  = (mem_rsp_data_i[6:0] == 7'b1101111);
    imm_j   = {{11{mem_rsp_data_i[31]}}, mem_rsp_data_i[31], mem_rsp_data_i[19:12],
               mem_rsp_data_i[20], mem_rsp_data_i[30:21], 1'b0};
    q_empty = (count_q == '0);
    q_full  = (count_q == FULL_CNT);
    // Flush suppresses every queue and request action in its cycle.
    issue   = rdy_i && !flush_i && (state_q == ST_IDLE) && !q_full;
    push    = rdy_i && !flush_i && (state_q == ST_WAIT) && mem_rsp_valid_i;
    pop     = rdy_i && !flush_i && !q_empty && out_ready_i;
    pc_d    = pc_q + (is_jal ? imm_j : 32'd4);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= 32'h0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
    end else begin
      // Request is a single-cycle pulse; it also drops while rdy_i is low.
      mem_req_valid_q <= issue;
      if (rdy_i) begin
        if (flush_i) begin
          pc_q    <= flush_pc_i;
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          // The outstanding response (if not arriving now) must still be swallowed.
          if (state_q == ST_WAIT) begin
            state_q <= mem_rsp_valid_i ? ST_IDLE : ST_DISCARD;
          end
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (issue) begin
                mem_req_addr_q <= pc_q;
                state_q        <= ST_WAIT;
              end
            end
            ST_WAIT: begin
              if (mem_rsp_valid_i) begin
                pc_q    <= pc_d;
                state_q <= ST_IDLE;
              end
            end
            ST_DISCARD: begin
              if (mem_rsp_valid_i) begin
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
          if (push) begin
            tail_q <= tail_q + 1'b1;
          end
          if (pop) begin
            head_q <= head_q + 1'b1;
          end
          count_q <= count_d;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[tail_q] <= mem_rsp_data_i;
      pc_mem[tail_q]    <= pc_q;
      jal_mem[tail_q]   <= is_jal;
    end
  end

  // Head outputs are forced to zero when empty so they are defined out of reset.
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_req_addr_o   = mem_req_addr_q;
  assign out_valid_o      = !q_empty;
  assign out_instr_o      = q_empty ? 32'h0 : instr_mem[head_q];
  assign out_pc_o         = q_empty ? 32'h0 : pc_mem[head_q];
  assign out_pred_taken_o = q_empty ? 1'b0 : jal_mem[head_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;

  logic        auto_mode = 1'b0;
  logic        jal_mode = 1'b0;
  logic        rsp_hold = 1'b0;
  logic        rsp_busy = 1'b0;
  logic        r_v = 1'b0;
  logic [31:0] r_d = 32'h0;
  logic        t_v = 1'b0;
  logic [31:0] t_d = 32'h0;

  int tests = 0;
  int fails = 0;
  logic [31:0] req_q[$];
  logic [64:0] pop_q[$];
  int req_base = 0;
  int pop_base = 0;

  localparam logic [31:0] I0 = 32'h00000093;
  localparam logic [31:0] I1 = 32'h00100093;
  localparam logic [31:0] I2 = 32'h00200093;
  localparam logic [31:0] JP = 32'h0200006F;
  localparam logic [31:0] JN = 32'hFF9FF06F;
  localparam logic [31:0] BQ = 32'h00000063;

  assign mem_rsp_valid = auto_mode ? r_v : t_v;
  assign mem_rsp_data  = auto_mode ? r_d : t_d;

  ifetch_queue #(.QUEUE_ADDR_W(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .flush_i(flush), .flush_pc_i(flush_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_pc_o(out_pc), .out_pred_taken_o(out_pred_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (jal_mode && a == 32'h10) return JP;
    return {a[13:2], 20'h00093};
  endfunction

  // Memory model: one response per request, three cycles after the request edge.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      if (auto_mode && mem_req_valid && !rst) begin
        rsp_busy = 1'b1;
        a = mem_req_addr;
        repeat (2) @(posedge clk);
        #1;
        while (rsp_hold) begin
          @(posedge clk); #1;
        end
        r_v = 1'b1;
        r_d = instr_of(a);
        @(posedge clk); #1;
        r_v = 1'b0;
        rsp_busy = 1'b0;
      end
    end
  end

  // Observer of issued requests and accepted queue entries.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_valid) req_q.push_back(mem_req_addr);
        if (rdy && !flush && out_valid && out_ready)
          pop_q.push_back({out_pred_taken, out_pc, out_instr});
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    auto_mode = 1'b0;
    for (int k = 0; k < 20 && rsp_busy; k++) @(posedge clk);
    jal_mode = 1'b0; rsp_hold = 1'b0; rdy = 1'b1; t_v = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    req_base = req_q.size();
    pop_base = pop_q.size();
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic check_stream(input string nm);
    for (int i = 0; i < pop_q.size() - pop_base; i++) begin
      chk($sformatf("%s.pc%0d", nm, i), pop_q[pop_base+i][63:32], 32'(4*i));
      chk($sformatf("%s.in%0d", nm, i), pop_q[pop_base+i][31:0], instr_of(32'(4*i)));
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        fl;
    logic [31:0] fp;
    logic        ordy;
    logic        em;
    logic [31:0] ea;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        epr;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic fl,
                              input logic [31:0] fp, input logic ordy, input logic em,
                              input logic [31:0] ea, input logic eov, input logic [31:0] epc,
                              input logic [31:0] ein, input logic epr);
    vec_t v;
    v.rv = rv; v.rd = rd; v.fl = fl; v.fp = fp; v.ordy = ordy;
    v.em = em; v.ea = ea; v.eov = eov; v.epc = epc; v.ein = ein; v.epr = epr;
    return v;
  endfunction

  initial begin
    vec_t vecs[30];
    bit   ok;
    int   n;
    vecs[0]  = mk(0, 0,  0, 0,       0, 1, 32'h0,   0, 0,       0,  0);
    vecs[1]  = mk(0, 0,  0, 0,       0, 0, 32'h0,   0, 0,       0,  0);
    vecs[2]  = mk(0, 0,  0, 0,       0, 0, 32'h0,   0, 0,       0,  0);
    vecs[3]  = mk(1, I0, 0, 0,       0, 0, 32'h0,   1, 32'h0,   I0, 0);
    vecs[4]  = mk(0, 0,  0, 0,       0, 1, 32'h4,   1, 32'h0,   I0, 0);
    vecs[5]  = mk(0, 0,  0, 0,       0, 0, 32'h4,   1, 32'h0,   I0, 0);
    vecs[6]  = mk(0, 0,  0, 0,       0, 0, 32'h4,   1, 32'h0,   I0, 0);
    vecs[7]  = mk(1, I1, 0, 0,       0, 0, 32'h4,   1, 32'h0,   I0, 0);
    vecs[8]  = mk(0, 0,  0, 0,       1, 1, 32'h8,   1, 32'h4,   I1, 0);
    vecs[9]  = mk(0, 0,  1, 32'h100, 1, 0, 32'h8,   0, 0,       0,  0);
    vecs[10] = mk(0, 0,  0, 0,       0, 0, 32'h8,   0, 0,       0,  0);
    vecs[11] = mk(1, I2, 0, 0,       0, 0, 32'h8,   0, 0,       0,  0);
    vecs[12] = mk(0, 0,  0, 0,       0, 1, 32'h100, 0, 0,       0,  0);
    vecs[13] = mk(0, 0,  0, 0,       0, 0, 32'h100, 0, 0,       0,  0);
    vecs[14] = mk(0, 0,  0, 0,       0, 0, 32'h100, 0, 0,       0,  0);
    vecs[15] = mk(1, JP, 0, 0,       0, 0, 32'h100, 1, 32'h100, JP, 1);
    vecs[16] = mk(0, 0,  0, 0,       0, 1, 32'h120, 1, 32'h100, JP, 1);
    vecs[17] = mk(0, 0,  0, 0,       1, 0, 32'h120, 0, 0,       0,  0);
    vecs[18] = mk(0, 0,  0, 0,       0, 0, 32'h120, 0, 0,       0,  0);
    vecs[19] = mk(1, JN, 0, 0,       0, 0, 32'h120, 1, 32'h120, JN, 1);
    vecs[20] = mk(0, 0,  0, 0,       0, 1, 32'h118, 1, 32'h120, JN, 1);
    vecs[21] = mk(1, I1, 1, 32'h200, 0, 0, 32'h118, 0, 0,       0,  0);
    vecs[22] = mk(0, 0,  0, 0,       0, 1, 32'h200, 0, 0,       0,  0);
    vecs[23] = mk(0, 0,  1, 32'h300, 0, 0, 32'h200, 0, 0,       0,  0);
    vecs[24] = mk(0, 0,  1, 32'h400, 0, 0, 32'h200, 0, 0,       0,  0);
    vecs[25] = mk(1, I0, 0, 0,       0, 0, 32'h200, 0, 0,       0,  0);
    vecs[26] = mk(0, 0,  1, 32'h500, 0, 0, 32'h200, 0, 0,       0,  0);
    vecs[27] = mk(0, 0,  0, 0,       0, 1, 32'h500, 0, 0,       0,  0);
    vecs[28] = mk(1, BQ, 0, 0,       0, 0, 32'h500, 1, 32'h500, BQ, 0);
    vecs[29] = mk(0, 0,  0, 0,       0, 1, 32'h504, 1, 32'h500, BQ, 0);

    // Reset values.
    do_reset();
    chk("rst.req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst.req_addr", mem_req_addr, 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_instr", out_instr, 32'h0);
    chk("rst.out_pc", out_pc, 32'h0);
    chk("rst.out_pred", 32'(out_pred_taken), 32'h0);

    // Cycle-accurate table: fetch, flush in every state, JAL +/- offsets, branch.
    for (int i = 0; i < 30; i++) begin
      t_v = vecs[i].rv; t_d = vecs[i].rd; flush = vecs[i].fl;
      flush_pc = vecs[i].fp; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d.req_valid", i), 32'(mem_req_valid), 32'(vecs[i].em));
      chk($sformatf("v%0d.req_addr", i), mem_req_addr, vecs[i].ea);
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      chk($sformatf("v%0d.out_pc", i), out_pc, vecs[i].epc);
      chk($sformatf("v%0d.out_instr", i), out_instr, vecs[i].ein);
      chk($sformatf("v%0d.out_pred", i), 32'(out_pred_taken), 32'(vecs[i].epr));
    end
    t_v = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // JAL at 0x10 redirects the next fetch to 0x30.
    do_reset();
    jal_mode = 1'b1; out_ready = 1'b1; auto_mode = 1'b1;
    for (int k = 0; k < 200 && (pop_q.size() - pop_base < 7); k++) cyc();
    ok = (pop_q.size() - pop_base >= 7) && (req_q.size() - req_base >= 7);
    chk("jal.timeout", 32'(ok), 32'h1);
    if (ok) begin
      chk("jal.req5", req_q[req_base+5], 32'h30);
      chk("jal.req6", req_q[req_base+6], 32'h34);
      chk("jal.pc4", pop_q[pop_base+4][63:32], 32'h10);
      chk("jal.pred4", 32'(pop_q[pop_base+4][64]), 32'h1);
      chk("jal.instr4", pop_q[pop_base+4][31:0], JP);
      chk("jal.pc5", pop_q[pop_base+5][63:32], 32'h30);
      chk("jal.pred5", 32'(pop_q[pop_base+5][64]), 32'h0);
      chk("jal.pred3", 32'(pop_q[pop_base+3][64]), 32'h0);
    end

    // Backpressure: queue fills to 16, fetch stops, then resumes at 0x40.
    do_reset();
    auto_mode = 1'b1;
    repeat (100) cyc();
    chk("full.reqs", 32'(req_q.size() - req_base), 32'd16);
    chk("full.count", 32'(dut.count_q), 32'd16);
    for (int i = 0; i < 16 && i < req_q.size() - req_base; i++)
      chk($sformatf("full.addr%0d", i), req_q[req_base+i], 32'(4*i));
    chk("full.out_pc", out_pc, 32'h0);
    n = req_q.size();
    repeat (20) cyc();
    chk("full.no_req", 32'(req_q.size()), 32'(n));
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (req_q.size() - req_base < 17); k++) cyc();
    ok = (req_q.size() - req_base >= 17);
    chk("full.resume", 32'(ok), 32'h1);
    if (ok) chk("full.addr16", req_q[req_base+16], 32'h40);
    repeat (150) cyc();
    out_ready = 1'b0;
    chk("full.drained", 32'(pop_q.size() - pop_base >= 40), 32'h1);
    check_stream("full");

    // Push and pop together at 15 entries; then drain across the pointer wrap.
    do_reset();
    auto_mode = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      cyc();
      ok = mem_rsp_valid && (req_q.size() - req_base == 16);
    end
    chk("wrap.timeout", 32'(ok), 32'h1);
    chk("wrap.count_pre", 32'(dut.count_q), 32'd15);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("wrap.count_post", 32'(dut.count_q), 32'd15);
    chk("wrap.pops", 32'(pop_q.size() - pop_base), 32'd1);
    chk("wrap.head_pc", out_pc, 32'h4);
    out_ready = 1'b1;
    repeat (120) cyc();
    out_ready = 1'b0;
    chk("wrap.drained", 32'(pop_q.size() - pop_base >= 25), 32'h1);
    check_stream("wrap");

    // rdy low mid-WAIT freezes everything; async reset mid-WAIT clears outputs at once.
    do_reset();
    auto_mode = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      cyc();
      ok = mem_req_valid && (mem_req_addr == 32'h4);
    end
    chk("rdy.timeout", 32'(ok), 32'h1);
    rsp_hold = 1'b1; rdy = 1'b0; out_ready = 1'b1;
    n = pop_q.size();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("rdy.ov%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("rdy.pc%0d", k), out_pc, 32'h0);
      chk($sformatf("rdy.req%0d", k), 32'(mem_req_valid), 32'h0);
    end
    chk("rdy.no_pop", 32'(pop_q.size()), 32'(n));
    chk("rdy.pc_frozen", dut.pc_q, 32'h4);
    rdy = 1'b1;
    cyc();
    chk("rdy.popped", 32'(pop_q.size()), 32'(n + 1));
    chk("rdy.empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0; rsp_hold = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) cyc();
    chk("rdy.resp_pc", out_pc, 32'h4);
    chk("rdy.resp_instr", out_instr, instr_of(32'h4));
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cyc();
      ok = mem_req_valid && (mem_req_addr == 32'h8);
    end
    chk("arst.req8", 32'(ok), 32'h1);
    rsp_hold = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.req_valid", 32'(mem_req_valid), 32'h0);
    chk("arst.req_addr", mem_req_addr, 32'h0);
    chk("arst.out_valid", 32'(out_valid), 32'h0);
    chk("arst.out_instr", out_instr, 32'h0);
    chk("arst.out_pc", out_pc, 32'h0);
    chk("arst.out_pred", 32'(out_pred_taken), 32'h0);
    auto_mode = 1'b0; rsp_hold = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
